// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared definitions for the PiStorm 68000 bus arbiter: state encodings and
// the status-register position of the external-ownership flag.
package m68k_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_WAIT_END  = 3'd1,
        ARB_GRANT     = 3'd2,
        ARB_EXT_OWNED = 3'd3,
        ARB_RELEASE   = 3'd4
    } arb_state_t;

    localparam int EXT_ACTIVE_BIT = 0;

endpackage

// File: rtl/m68k_bus_arbiter_sync.sv
// N-stage synchroniser for the asynchronous active-low 68000 bus signals.
// Resets to 1 so the request inputs read as negated.
module pistorm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus-mastership arbiter: runs the BR/BG/BGACK handshake with external
// DMA masters and tells the Pi cycle engine when it may start or must release.
module m68k_bus_arbiter
    import m68k_bus_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             PI_CLK,
    input  logic             RESET_n,
    input  logic             c7m_rising,
    input  logic             c7m_falling,
    input  logic             M68K_BR_n,
    input  logic             M68K_BGACK_n,
    input  logic             pi_busy,
    output logic             pi_grant,
    output logic             M68K_BG_n,
    output logic             bus_release,
    output logic             ext_active,
    output logic [CNT_W-1:0] ext_clk_count,
    input  logic             count_clr
);

    arb_state_t state;
    arb_state_t next_state;
    logic       br_n_sync;
    logic       bgack_n_sync;
    logic       br;
    logic       bgack;
    logic       unused_rising;

    // The engine consumes c7m_rising itself; here only falling edges matter.
    assign unused_rising = c7m_rising;

    pistorm_sync #(.STAGES(SYNC_STAGES)) u_sync_br (
        .clk   (PI_CLK),
        .rst_n (RESET_n),
        .d     (M68K_BR_n),
        .q     (br_n_sync)
    );

    pistorm_sync #(.STAGES(SYNC_STAGES)) u_sync_bgack (
        .clk   (PI_CLK),
        .rst_n (RESET_n),
        .d     (M68K_BGACK_n),
        .q     (bgack_n_sync)
    );

    assign br    = ~br_n_sync;
    assign bgack = ~bgack_n_sync;

    always_comb begin
        next_state = state;
        unique case (state)
            ARB_IDLE: begin
                // A master that skipped BG still gets the bus once the engine is idle.
                if (bgack || br) begin
                    if (pi_busy)    next_state = ARB_WAIT_END;
                    else if (bgack) next_state = ARB_EXT_OWNED;
                    else            next_state = ARB_GRANT;
                end
            end
            ARB_WAIT_END: begin
                if (!br && !bgack) next_state = ARB_IDLE;
                else if (!pi_busy) next_state = bgack ? ARB_EXT_OWNED : ARB_GRANT;
            end
            ARB_GRANT: begin
                if (bgack)    next_state = ARB_EXT_OWNED;
                else if (!br) next_state = ARB_RELEASE;
            end
            ARB_EXT_OWNED: begin
                if (!bgack) next_state = br ? ARB_GRANT : ARB_RELEASE;
            end
            ARB_RELEASE: next_state = ARB_IDLE;
            default:     next_state = ARB_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it, so
    // they move only on M68K falling edges, away from the engine's S1 decision.
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= ARB_IDLE;
            pi_grant    <= 1'b1;
            M68K_BG_n   <= 1'b1;
            bus_release <= 1'b0;
            ext_active  <= 1'b0;
        end else if (c7m_falling) begin
            state       <= next_state;
            pi_grant    <= (next_state == ARB_IDLE);
            M68K_BG_n   <= (next_state != ARB_GRANT);
            bus_release <= (next_state == ARB_GRANT) || (next_state == ARB_EXT_OWNED) ||
                           (next_state == ARB_RELEASE);
            ext_active  <= (next_state == ARB_EXT_OWNED);
        end
    end

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ext_clk_count <= '0;
        end else if (count_clr) begin
            ext_clk_count <= '0;
        end else if (c7m_falling && state == ARB_EXT_OWNED && ext_clk_count != '1) begin
            ext_clk_count <= ext_clk_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed self-checking bench for m68k_bus_arbiter: handshake sequences,
// re-arbitration, counter saturation/clear and asynchronous reset.
module tb_m68k_bus_arbiter;

    logic        PI_CLK = 1'b0;
    logic        RESET_n;
    logic        c7m_rising = 1'b0;
    logic        c7m_falling = 1'b0;
    logic        M68K_BR_n;
    logic        M68K_BGACK_n;
    logic        pi_busy;
    logic        pi_grant;
    logic        M68K_BG_n;
    logic        bus_release;
    logic        ext_active;
    logic [15:0] ext_clk_count;
    logic        count_clr;

    int          total = 0;
    int          bad = 0;
    int          phase = 0;
    logic        fast = 1'b0;

    m68k_bus_arbiter #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .PI_CLK        (PI_CLK),
        .RESET_n       (RESET_n),
        .c7m_rising    (c7m_rising),
        .c7m_falling   (c7m_falling),
        .M68K_BR_n     (M68K_BR_n),
        .M68K_BGACK_n  (M68K_BGACK_n),
        .pi_busy       (pi_busy),
        .pi_grant      (pi_grant),
        .M68K_BG_n     (M68K_BG_n),
        .bus_release   (bus_release),
        .ext_active    (ext_active),
        .ext_clk_count (ext_clk_count),
        .count_clr     (count_clr)
    );

    always #5 PI_CLK = ~PI_CLK;

    // M68K clock model: 8 PI_CLK per M68K clock, or a falling strobe every
    // PI_CLK in fast mode so the counter can be driven to saturation quickly.
    always @(negedge PI_CLK) begin
        if (fast) begin
            c7m_rising  = 1'b0;
            c7m_falling = 1'b1;
        end else begin
            phase       = (phase + 1) % 8;
            c7m_rising  = (phase == 0);
            c7m_falling = (phase == 4);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_fall();
        bit got = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge PI_CLK);
            if (c7m_falling) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL next_fall: observed=no_strobe expected=strobe");
        end
        #1;
    endtask

    task automatic check_all(input string tag, input logic grant, input logic bg_n,
                             input logic rel, input logic ext);
        checkOutput({tag, ".pi_grant"}, {31'd0, pi_grant}, {31'd0, grant});
        checkOutput({tag, ".BG_n"}, {31'd0, M68K_BG_n}, {31'd0, bg_n});
        checkOutput({tag, ".bus_release"}, {31'd0, bus_release}, {31'd0, rel});
        checkOutput({tag, ".ext_active"}, {31'd0, ext_active}, {31'd0, ext});
    endtask

    initial begin
        RESET_n      = 1'b0;
        M68K_BR_n    = 1'b1;
        M68K_BGACK_n = 1'b1;
        pi_busy      = 1'b0;
        count_clr    = 1'b0;
        #23;
        check_all("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reset.count", {16'd0, ext_clk_count}, 32'd0);
        @(negedge PI_CLK);
        RESET_n = 1'b1;
        repeat (4) @(posedge PI_CLK);
        next_fall();
        check_all("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // 1: idle bus, request granted on the first falling edge
        M68K_BR_n = 1'b0;
        next_fall();
        check_all("t1.grant", 1'b0, 1'b0, 1'b1, 1'b0);
        M68K_BGACK_n = 1'b0;
        M68K_BR_n    = 1'b1;
        next_fall();
        check_all("t1.owned", 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t1.count", {16'd0, ext_clk_count}, 32'd0);

        // 3: ten M68K clocks of ownership, then release turnaround
        repeat (9) next_fall();
        checkOutput("t3.count9", {16'd0, ext_clk_count}, 32'd9);
        M68K_BGACK_n = 1'b1;
        next_fall();
        check_all("t3.release", 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t3.count10", {16'd0, ext_clk_count}, 32'd10);
        next_fall();
        check_all("t3.idle", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t3.count_hold", {16'd0, ext_clk_count}, 32'd10);
        count_clr = 1'b1;
        @(posedge PI_CLK);
        #1 count_clr = 1'b0;
        checkOutput("t3.count_clr", {16'd0, ext_clk_count}, 32'd0);

        // 2: request while the engine is mid-cycle
        pi_busy   = 1'b1;
        M68K_BR_n = 1'b0;
        next_fall();
        check_all("t2.wait", 1'b0, 1'b1, 1'b0, 1'b0);
        next_fall();
        check_all("t2.wait2", 1'b0, 1'b1, 1'b0, 1'b0);
        pi_busy = 1'b0;
        next_fall();
        check_all("t2.grant", 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: request withdrawn before BGACK
        M68K_BR_n = 1'b1;
        next_fall();
        check_all("t4.release", 1'b0, 1'b1, 1'b1, 1'b0);
        next_fall();
        check_all("t4.idle", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t4.count", {16'd0, ext_clk_count}, 32'd0);

        // 5: second master waiting when the first lets go
        M68K_BR_n = 1'b0;
        next_fall();
        check_all("t5.grant1", 1'b0, 1'b0, 1'b1, 1'b0);
        M68K_BGACK_n = 1'b0;
        M68K_BR_n    = 1'b1;
        next_fall();
        check_all("t5.owned1", 1'b0, 1'b1, 1'b1, 1'b1);
        M68K_BGACK_n = 1'b1;
        M68K_BR_n    = 1'b0;
        next_fall();
        check_all("t5.regrant", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5.count", {16'd0, ext_clk_count}, 32'd1);
        M68K_BGACK_n = 1'b0;
        M68K_BR_n    = 1'b1;
        next_fall();
        check_all("t5.owned2", 1'b0, 1'b1, 1'b1, 1'b1);
        M68K_BGACK_n = 1'b1;
        next_fall();
        check_all("t5.release", 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t5.count2", {16'd0, ext_clk_count}, 32'd2);
        next_fall();

        // BGACK without BR while engine busy: wait, then take the bus directly
        pi_busy      = 1'b1;
        M68K_BGACK_n = 1'b0;
        next_fall();
        check_all("bgack.wait", 1'b0, 1'b1, 1'b0, 1'b0);
        pi_busy = 1'b0;
        next_fall();
        check_all("bgack.owned", 1'b0, 1'b1, 1'b1, 1'b1);

        // 6: saturate the counter, then reset while owned
        fast      = 1'b1;
        count_clr = 1'b1;
        @(posedge PI_CLK);
        #1 count_clr = 1'b0;
        checkOutput("t6.clr_over_inc", {16'd0, ext_clk_count}, 32'd0);
        repeat (65540) @(posedge PI_CLK);
        #1;
        checkOutput("t6.saturate", {16'd0, ext_clk_count}, 32'h0000FFFF);
        repeat (3) @(posedge PI_CLK);
        #1;
        checkOutput("t6.sat_hold", {16'd0, ext_clk_count}, 32'h0000FFFF);
        #2 RESET_n = 1'b0;
        #1;
        check_all("t6.reset", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6.reset_count", {16'd0, ext_clk_count}, 32'd0);
        @(negedge PI_CLK);
        RESET_n = 1'b1;
        repeat (10) @(posedge PI_CLK);
        #1;
        checkOutput("t6.recount", {16'd0, ext_clk_count}, 32'd7);
        checkOutput("t6.reowned", {31'd0, ext_active}, 32'd1);
        @(negedge PI_CLK);
        count_clr = 1'b1;
        @(negedge PI_CLK);
        checkOutput("t6.clr_pending", {16'd0, ext_clk_count}, 32'd0);
        count_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
